// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, step encoding,
// IR field positions and the strobe bundle.
package cpu_defs;

    localparam int OP_MSB = 31;
    localparam int RA_MSB = 26;
    localparam int RB_MSB = 22;
    localparam int RC_MSB = 18;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_MULDIV, CL_NOP, CL_HALT, CL_ILL
    } op_class_t;

    typedef struct packed {
        logic PCout;
        logic Zhighout;
        logic Zlowout;
        logic MDRout;
        logic HIout;
        logic LOout;
        logic PCin;
        logic MARin;
        logic MDRin;
        logic IRin;
        logic Yin;
        logic Zin;
        logic HIin;
        logic LOin;
        logic IncPC;
        logic Read;
    } strobes_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:     return CL_ALU;
            OP_MUL, OP_DIV:                      return CL_MULDIV;
            OP_NOP:                              return CL_NOP;
            OP_HALT:                             return CL_HALT;
            default:                             return CL_ILL;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR and Stop come in, all control strobes go out.
interface control_sequencer_if #(
    parameter int OPW  = 5,
    parameter int REGW = 4
);
    logic [31:0]          IR;
    logic                 Stop;
    logic                 PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic                 PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic                 IncPC, Read;
    logic [(1<<REGW)-1:0] Rin, Rout;
    logic [OPW-1:0]       opcode;
    logic                 Run, Illegal;

    modport master (
        input  IR, Stop,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Rin, Rout, opcode, Run, Illegal
    );

    modport slave (
        output IR, Stop,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Rin, Rout, opcode, Run, Illegal
    );
endinterface

// File: rtl/control_sequencer_reg_select.sv
// One-hot general-register select: picks Ra/Rb/Rc from IR and qualifies it
// onto the load (Rin) or drive (Rout) enables.
module reg_select
    import cpu_defs::*;
#(
    parameter int REGW = 4
) (
    input  logic [31:0]          i_ir,
    input  logic                 i_gra,
    input  logic                 i_grb,
    input  logic                 i_grc,
    input  logic                 i_rin,
    input  logic                 i_rout,
    output logic [(1<<REGW)-1:0] o_rin,
    output logic [(1<<REGW)-1:0] o_rout
);
    logic [REGW-1:0]        w_sel;
    logic                   w_any;
    logic [(1<<REGW)-1:0]   w_hot;

    assign w_sel = ({REGW{i_gra}} & i_ir[RA_MSB -: REGW])
                 | ({REGW{i_grb}} & i_ir[RB_MSB -: REGW])
                 | ({REGW{i_grc}} & i_ir[RC_MSB -: REGW]);
    assign w_any = i_gra | i_grb | i_grc;

    for (genvar g = 0; g < (1 << REGW); g++) begin : g_hot
        assign w_hot[g] = w_any && (w_sel == REGW'(g));
    end

    assign o_rin  = i_rin  ? w_hot : '0;
    assign o_rout = i_rout ? w_hot : '0;
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, then execute steps per opcode class,
// one Moore control step per clock.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW  = 5,
    parameter int REGW = 4
) (
    input  logic                  Clock,
    input  logic                  Clear,
    control_sequencer_if.master   bus
);
    state_t               r_state, w_next;
    logic [OPW-1:0]       r_opcode, w_opcode, w_op;
    op_class_t            w_cls;
    strobes_t             w_stb;
    logic                 w_gra, w_grb, w_grc, w_rin_q, w_rout_q;
    logic                 w_run, w_ill;
    logic [(1<<REGW)-1:0] w_rin, w_rout;
    logic                 w_unused_ir;

    assign w_op        = bus.IR[OP_MSB -: OPW];
    assign w_cls       = op_class(w_op);
    assign w_unused_ir = ^bus.IR[14:0];

    // opcode is a held value: it only changes in steps that drive it
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            r_state  <= S_RST;
            r_opcode <= '0;
        end else begin
            r_state  <= w_next;
            r_opcode <= w_opcode;
        end
    end

    always_comb begin
        w_next = S_RST;
        case (r_state)
            S_RST: w_next = T0;
            T0:    w_next = T1;
            T1:    w_next = T2;
            T2:    w_next = T3;
            T3: begin
                case (w_cls)
                    CL_ALU, CL_MULDIV: w_next = T4;
                    CL_HALT:           w_next = S_HALT;
                    default:           w_next = bus.Stop ? S_HALT : T0;
                endcase
            end
            T4:     w_next = T5;
            T5:     w_next = (w_cls == CL_MULDIV) ? T6 : (bus.Stop ? S_HALT : T0);
            T6:     w_next = bus.Stop ? S_HALT : T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    always_comb begin
        w_stb    = '0;
        w_gra    = 1'b0;
        w_grb    = 1'b0;
        w_grc    = 1'b0;
        w_rin_q  = 1'b0;
        w_rout_q = 1'b0;
        w_opcode = r_opcode;
        w_run    = 1'b1;
        w_ill    = 1'b0;
        case (r_state)
            T0: begin
                w_stb.PCout = 1'b1;
                w_stb.MARin = 1'b1;
                w_stb.IncPC = 1'b1;
                w_stb.Zin   = 1'b1;
                w_opcode    = OP_ADD;
            end
            T1: begin
                w_stb.Zlowout = 1'b1;
                w_stb.PCin    = 1'b1;
                w_stb.Read    = 1'b1;
                w_stb.MDRin   = 1'b1;
            end
            T2: begin
                w_stb.MDRout = 1'b1;
                w_stb.IRin   = 1'b1;
            end
            T3: begin
                // ALU ops take the first operand from Rb, mul/div from Ra
                if (w_cls == CL_ALU || w_cls == CL_MULDIV) begin
                    w_gra     = (w_cls == CL_MULDIV);
                    w_grb     = (w_cls == CL_ALU);
                    w_rout_q  = 1'b1;
                    w_stb.Yin = 1'b1;
                end
                w_ill = (w_cls == CL_ILL);
            end
            T4: begin
                w_grb     = (w_cls == CL_MULDIV);
                w_grc     = (w_cls != CL_MULDIV);
                w_rout_q  = 1'b1;
                w_stb.Zin = 1'b1;
                w_opcode  = w_op;
            end
            T5: begin
                w_stb.Zlowout = 1'b1;
                if (w_cls == CL_MULDIV) begin
                    w_stb.LOin = 1'b1;
                end else begin
                    w_gra   = 1'b1;
                    w_rin_q = 1'b1;
                end
            end
            T6: begin
                w_stb.Zhighout = 1'b1;
                w_stb.HIin     = 1'b1;
            end
            S_HALT: w_run = 1'b0;
            default: ;
        endcase
    end

    reg_select #(.REGW(REGW)) u_reg_select (
        .i_ir   (bus.IR),
        .i_gra  (w_gra),
        .i_grb  (w_grb),
        .i_grc  (w_grc),
        .i_rin  (w_rin_q),
        .i_rout (w_rout_q),
        .o_rin  (w_rin),
        .o_rout (w_rout)
    );

    assign bus.PCout    = w_stb.PCout;
    assign bus.Zhighout = w_stb.Zhighout;
    assign bus.Zlowout  = w_stb.Zlowout;
    assign bus.MDRout   = w_stb.MDRout;
    assign bus.HIout    = w_stb.HIout;
    assign bus.LOout    = w_stb.LOout;
    assign bus.PCin     = w_stb.PCin;
    assign bus.MARin    = w_stb.MARin;
    assign bus.MDRin    = w_stb.MDRin;
    assign bus.IRin     = w_stb.IRin;
    assign bus.Yin      = w_stb.Yin;
    assign bus.Zin      = w_stb.Zin;
    assign bus.HIin     = w_stb.HIin;
    assign bus.LOin     = w_stb.LOin;
    assign bus.IncPC    = w_stb.IncPC;
    assign bus.Read     = w_stb.Read;
    assign bus.Rin      = w_rin;
    assign bus.Rout     = w_rout;
    assign bus.opcode   = w_opcode;
    assign bus.Run      = w_run;
    assign bus.Illegal  = w_ill;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: per-cycle vector table for the instruction flows, then
// hand-written sequences for pulse width, instruction length and halt.
module tb_control_sequencer;
    localparam logic [15:0] B_PCOUT = 16'h8000, B_ZHI  = 16'h4000, B_ZLO   = 16'h2000;
    localparam logic [15:0] B_MDROUT= 16'h1000, B_HIOUT= 16'h0800, B_LOOUT = 16'h0400;
    localparam logic [15:0] B_PCIN  = 16'h0200, B_MARIN= 16'h0100, B_MDRIN = 16'h0080;
    localparam logic [15:0] B_IRIN  = 16'h0040, B_YIN  = 16'h0020, B_ZIN   = 16'h0010;
    localparam logic [15:0] B_HIIN  = 16'h0008, B_LOIN = 16'h0004, B_INCPC = 16'h0002;
    localparam logic [15:0] B_READ  = 16'h0001;
    localparam logic [15:0] F0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [15:0] F1 = B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [15:0] F2 = B_MDROUT | B_IRIN;

    localparam logic [31:0] I_AND  = 32'h28918000;
    localparam logic [31:0] I_SHL  = 32'h4A918000;
    localparam logic [31:0] I_MUL  = 32'h79180000;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_ILL  = 32'hF8000000;
    localparam logic [31:0] I_SUB  = 32'h222B0000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_ADD  = 32'h18918000;
    localparam logic [31:0] I_M77  = 32'h7BB80000;

    typedef struct {
        logic        clr;
        logic        stp;
        logic [31:0] mem;
        logic [15:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic        run;
        logic        ill;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        stop  = 1'b0;
    logic [31:0] mem_word = 32'h0;
    logic [31:0] r_ir = 32'h0;
    int          total = 0;
    int          bad   = 0;
    vec_t        vq[$];

    control_sequencer_if #(.OPW(5), .REGW(4)) bus ();

    control_sequencer dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // datapath stand-in: IR takes the fetched word on IRin
    always @(posedge Clock) if (bus.IRin) r_ir <= mem_word;
    assign bus.IR   = r_ir;
    assign bus.Stop = stop;

    function automatic logic [15:0] strobes();
        return {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout,
                bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin,
                bus.HIin, bus.LOin, bus.IncPC, bus.Read};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic row(input logic clr, input logic stp, input logic [31:0] mem,
                       input logic [15:0] strb, input logic [15:0] rin, input logic [15:0] rout,
                       input logic [4:0] op, input logic run, input logic ill);
        vq.push_back('{clr, stp, mem, strb, rin, rout, op, run, ill});
    endtask

    task automatic fetch(input logic [31:0] mem, input logic stp);
        row(1, stp, mem, F0, 0, 0, 5'd3, 1, 0);
        row(1, stp, mem, F1, 0, 0, 5'd3, 1, 0);
        row(1, stp, mem, F2, 0, 0, 5'd3, 1, 0);
    endtask

    initial begin
        int n;
        int ills;
        int hot;
        logic [63:0] act, exp;

        // reset, then and R1,R2,R3
        row(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
        row(0, 0, 0, 0, 0, 0, 5'd0, 1, 0);
        fetch(I_AND, 0);
        row(1, 0, I_AND, B_YIN, 0, 16'h0004, 5'd3, 1, 0);
        row(1, 0, I_AND, B_ZIN, 0, 16'h0008, 5'd5, 1, 0);
        row(1, 0, I_AND, B_ZLO, 16'h0002, 0, 5'd5, 1, 0);
        // shl R5,R2,R3
        fetch(I_SHL, 0);
        row(1, 0, I_SHL, B_YIN, 0, 16'h0004, 5'd3, 1, 0);
        row(1, 0, I_SHL, B_ZIN, 0, 16'h0008, 5'd9, 1, 0);
        row(1, 0, I_SHL, B_ZLO, 16'h0020, 0, 5'd9, 1, 0);
        // mul R2,R3
        fetch(I_MUL, 0);
        row(1, 0, I_MUL, B_YIN, 0, 16'h0004, 5'd3, 1, 0);
        row(1, 0, I_MUL, B_ZIN, 0, 16'h0008, 5'd15, 1, 0);
        row(1, 0, I_MUL, B_ZLO | B_LOIN, 0, 0, 5'd15, 1, 0);
        row(1, 0, I_MUL, B_ZHI | B_HIIN, 0, 0, 5'd15, 1, 0);
        // nop, then undecoded opcode
        fetch(I_NOP, 0);
        row(1, 0, I_NOP, 0, 0, 0, 5'd3, 1, 0);
        fetch(I_ILL, 0);
        row(1, 0, I_ILL, 0, 0, 0, 5'd3, 1, 1);
        // sub R4,R5,R6 with Stop raised mid-instruction: completes, then halts
        fetch(I_SUB, 0);
        row(1, 0, I_SUB, B_YIN, 0, 16'h0020, 5'd3, 1, 0);
        row(1, 1, I_SUB, B_ZIN, 0, 16'h0040, 5'd4, 1, 0);
        row(1, 1, I_SUB, B_ZLO, 16'h0010, 0, 5'd4, 1, 0);
        row(1, 1, I_SUB, 0, 0, 0, 5'd4, 0, 0);
        for (int i = 0; i < 19; i++) row(1, 0, I_SUB, 0, 0, 0, 5'd4, 0, 0);
        // Clear out of halt; nop with Stop held through fetch halts only after T3
        row(0, 0, I_NOP, 0, 0, 0, 5'd0, 1, 0);
        fetch(I_NOP, 1);
        row(1, 1, I_NOP, 0, 0, 0, 5'd3, 1, 0);
        row(1, 1, I_NOP, 0, 0, 0, 5'd3, 0, 0);
        // halt instruction
        row(0, 0, I_HALT, 0, 0, 0, 5'd0, 1, 0);
        fetch(I_HALT, 0);
        row(1, 0, I_HALT, 0, 0, 0, 5'd3, 1, 0);
        row(1, 0, I_HALT, 0, 0, 0, 5'd3, 0, 0);
        row(1, 0, I_HALT, 0, 0, 0, 5'd3, 0, 0);
        // add abandoned by Clear in T4, then mul R7,R7 (Ra==Rb)
        row(0, 0, I_ADD, 0, 0, 0, 5'd0, 1, 0);
        fetch(I_ADD, 0);
        row(1, 0, I_ADD, B_YIN, 0, 16'h0004, 5'd3, 1, 0);
        row(1, 0, I_ADD, B_ZIN, 0, 16'h0008, 5'd3, 1, 0);
        row(0, 0, I_ADD, 0, 0, 0, 5'd0, 1, 0);
        fetch(I_M77, 0);
        row(1, 0, I_M77, B_YIN, 0, 16'h0080, 5'd3, 1, 0);
        row(1, 0, I_M77, B_ZIN, 0, 16'h0080, 5'd15, 1, 0);
        row(1, 0, I_M77, B_ZLO | B_LOIN, 0, 0, 5'd15, 1, 0);
        row(1, 0, I_M77, B_ZHI | B_HIIN, 0, 0, 5'd15, 1, 0);

        foreach (vq[i]) begin
            Clear    = vq[i].clr;
            stop     = vq[i].stp;
            mem_word = vq[i].mem;
            tick();
            act = {9'h0, strobes(), bus.Rin, bus.Rout, bus.opcode, bus.Run, bus.Illegal};
            exp = {9'h0, vq[i].strb, vq[i].rin, vq[i].rout, vq[i].op, vq[i].run, vq[i].ill};
            chk($sformatf("row%0d", i), act, exp);
        end

        // Illegal is a single-cycle pulse with no register enables
        Clear = 1'b0; stop = 1'b0; mem_word = I_ILL;
        tick();
        Clear = 1'b1;
        ills = 0; hot = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.Illegal) begin
                ills++;
                if (bus.Rin != 0 || bus.Rout != 0) hot++;
            end
        end
        chk("illegal_pulses", 64'(ills), 64'd1);
        chk("illegal_no_regs", 64'(hot), 64'd0);

        // mul occupies 7 steps from T0 to the next T0
        Clear = 1'b0; mem_word = I_MUL;
        tick();
        Clear = 1'b1;
        n = 0;
        while (!bus.PCout && n < 10) begin tick(); n++; end
        chk("mul_t0_seen", 64'(bus.PCout), 64'd1);
        n = 0;
        do begin tick(); n++; end while (!bus.PCout && n < 20);
        chk("mul_length", 64'(n), 64'd7);

        // halt: Run drops after T3, strobes stay quiet, Clear resumes fetch
        Clear = 1'b0; mem_word = I_HALT;
        tick();
        Clear = 1'b1;
        n = 0;
        while (bus.Run && n < 12) begin tick(); n++; end
        chk("halt_latency", 64'(n), 64'd5);
        hot = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (strobes() != 0 || bus.Rin != 0 || bus.Rout != 0 || bus.Run) hot++;
        end
        chk("halt_quiet", 64'(hot), 64'd0);
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        tick();
        chk("resume_t0", {48'h0, strobes()}, {48'h0, F0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
